bcd_conv_ctrl: RTL and testbench
================================

Name: bcd_conv_ctrl

Overview:
Sequential binary-to-BCD conversion controller for the 4-digit CoolRunner-II display path. Accepts a binary count on a start/busy/done handshake and runs a shift-and-add-3 (double-dabble) sequence one bit per clock. Registers the four BCD digits A (thousands) to D (units) for the display scan logic. Values above 9999 saturate to 9999 and raise an overflow flag.

Parameters:
WIDTH, 14, binary input width. Legal range 4..14. Iteration count = WIDTH.
MAXVAL, 9999, saturation limit. Must be ≤ 9999 and < 2**WIDTH when WIDTH = 14.

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  asynchronous, active-low reset (0 = reset)
start  input  1  conversion request, sampled only in IDLE
value  input  WIDTH  binary value, sampled on the accepting edge only
busy  output  1  high while a conversion is in progress
done  output  1  one-cycle pulse when A..D and ovf are updated
ovf  output  1  sticky until next completion: last input exceeded MAXVAL
A  output  4  thousands digit
B  output  4  hundreds digit
C  output  4  tens digit
D  output  4  units digit

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, ovf=0, A=B=C=D=4'h0; shift and BCD work registers cleared. Reset mid-conversion aborts it with no done pulse. Outputs hold reset values until the first completion.
- States: IDLE, SHIFT, FINISH.
- IDLE: busy=0. On an edge with start=1, the block moves to SHIFT and sets busy=1.
  - At that edge it loads bin_sr = (value > MAXVAL) ? MAXVAL : value, sets ovf_pend = (value > MAXVAL), clears the 16-bit BCD work register, and sets cnt=0.
- SHIFT, one edge per bit:
  - Each BCD nibble ≥ 5 gets +3.
  - Then {bcd, bin_sr} shifts left 1 bit, MSB first.
  - cnt increments.
  - On the edge where cnt == WIDTH-1, the state moves to FINISH.
- FINISH, one edge:
  - A..D are loaded from the work register.
  - ovf is loaded from ovf_pend.
  - done=1 for exactly one cycle.
  - busy=0 and the state returns to IDLE.
- Latency: start accepted at edge t0 → shift edges t1..tWIDTH → results and done valid after edge tWIDTH+1. With WIDTH=14, done is high for the cycle after edge t15.
- Throughput: start can be accepted on the edge after FINISH, so back-to-back requests take WIDTH+2 cycles each.
- start while busy=1 is ignored and not queued.
- value changes after acceptance have no effect.
- A..D hold their previous result throughout a conversion; there are no intermediate values on the outputs.
- Arithmetic:
  - The add-3 is applied to each nibble independently.
  - No nibble exceeds 9 after a completed conversion, since input ≤ MAXVAL ≤ 9999.
  - Width rules: work register 16 bits; counter $clog2(WIDTH) bits.
- Boundaries:
  - value=0 → 0,0,0,0.
  - value=MAXVAL → exact digits, ovf=0.
  - value=MAXVAL+1 → saturated digits, ovf=1.
  - All-ones input → saturated, ovf=1.

Optional Feature:
BCD_BLANK_EN:
- Defined: leading-zero blanking, applied in FINISH.
  - Leading zero digits, scanning A→C, are output as 4'hF (blank code for the segment decoder).
  - D is never blanked.
  - Example: 42 → F,F,4,2; 0 → F,F,F,0.
  - Reset values stay 4'h0.
- Undefined: digits are always output as plain BCD, and no blanking logic is synthesized.

Decomposition:
Shared package bcd_pkg:
- state enum encoding (IDLE=2'd0, SHIFT=2'd1, FINISH=2'd2)
- BCD_BLANK = 4'hF
- DIGITS = 4
- default MAXVAL constant
One combinational sub-module, bcd_add3 (4-bit in → 4-bit out, +3 when ≥ 5), instantiated four times in the shift datapath. The controller FSM stays in bcd_conv_ctrl.

Test Plan:
1. Reset released, start pulse with value=1234 → busy high for cycles 1..15. done pulses after edge 15 with A,B,C,D = 1,2,3,4 and ovf=0.
2. value=0, then value=9999 → 0,0,0,0 then 9,9,9,9, both with ovf=0.
3. value=12000 → 9,9,9,9 with ovf=1. Next conversion with value=5 → 0,0,0,5 with ovf=0.
4. start with value=4321, then start held high with value=1111 during busy → only one done, result 4,3,2,1. Second request accepted only after IDLE.
5. rst pulled low at cycle 7 of a conversion of 8765 → outputs 0 immediately, no done. After release, a new conversion of 8765 completes normally.
6. Back-to-back requests 42 then 7 (start re-asserted the cycle done is high) → second done 16 cycles after the first. With BCD_BLANK_EN the results are F,F,4,2 and F,F,F,7.

Source files
------------

// File: rtl/bcd_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// Optional leading-zero blanking is selected with BCD_BLANK_EN.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam logic [3:0] BCD_BLANK  = 4'hF;
    localparam int         DIGITS     = 4;
    localparam int         MAXVAL_DEF = 9999;

endpackage

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: add 3 to a BCD nibble when >= 5.
// Purely combinational, one instance per digit.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bcd_conv_ctrl.sv
// Sequential binary-to-BCD converter, one bit per clock, saturating.
// Define BCD_BLANK_EN for leading-zero blanking of digits A..C.
module bcd_conv_ctrl
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 14,
    parameter int MAXVAL = MAXVAL_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [3:0]       A,
    output logic [3:0]       B,
    output logic [3:0]       C,
    output logic [3:0]       D
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] SATV = WIDTH'(MAXVAL);

    state_t state, nstate;

    logic [WIDTH-1:0] bin_sr;
    logic [15:0]      bcd;
    logic [15:0]      bcd_adj;
    logic [15:0]      res;
    logic [CW-1:0]    cnt;
    logic             ovf_pend;
    logic             over;
    logic             load;
    logic             shift_en;
    logic             fin;

    // Compare at 32 bits so MAXVAL may exceed the input range.
    assign over = 32'(value) > 32'(MAXVAL);

    for (genvar i = 0; i < DIGITS; i++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (bcd[4*i +: 4]),
            .dout (bcd_adj[4*i +: 4])
        );
    end

`ifdef BCD_BLANK_EN
    always_comb begin
        res = bcd;
        if (bcd[15:12] == 4'd0) begin
            res[15:12] = BCD_BLANK;
            if (bcd[11:8] == 4'd0) begin
                res[11:8] = BCD_BLANK;
                if (bcd[7:4] == 4'd0) begin
                    res[7:4] = BCD_BLANK;
                end
            end
        end
    end
`else
    assign res = bcd;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= nstate;
        end
    end

    always_comb begin
        nstate = state;
        unique case (state)
            IDLE:    if (start) nstate = SHIFT;
            SHIFT:   if (cnt == LAST) nstate = FINISH;
            FINISH:  nstate = IDLE;
            default: nstate = IDLE;
        endcase
    end

    always_comb begin
        busy     = 1'b0;
        load     = 1'b0;
        shift_en = 1'b0;
        fin      = 1'b0;
        unique case (state)
            IDLE:    load = start;
            SHIFT: begin
                busy     = 1'b1;
                shift_en = 1'b1;
            end
            FINISH: begin
                busy = 1'b1;
                fin  = 1'b1;
            end
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bin_sr   <= '0;
            bcd      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            done     <= 1'b0;
            ovf      <= 1'b0;
            A        <= 4'h0;
            B        <= 4'h0;
            C        <= 4'h0;
            D        <= 4'h0;
        end else begin
            done <= fin;
            if (load) begin
                bin_sr   <= over ? SATV : value;
                ovf_pend <= over;
                bcd      <= '0;
                cnt      <= '0;
            end else if (shift_en) begin
                {bcd, bin_sr} <= {bcd_adj, bin_sr} << 1;
                cnt           <= cnt + CW'(1);
            end
            if (fin) begin
                {A, B, C, D} <= res;
                ovf          <= ovf_pend;
            end
        end
    end

endmodule

// File: tb/tb_bcd_conv_ctrl.sv
// Self-checking bench for bcd_conv_ctrl: arithmetic model plus
// directed and randomized stimulus.
module tb_bcd_conv_ctrl;

    localparam int W    = 14;
    localparam int MAXV = 9999;
    localparam int LAT  = W + 1;

`ifdef BCD_BLANK_EN
    localparam logic [15:0] E_0    = 16'hFFF0;
    localparam logic [15:0] E_5    = 16'hFFF5;
    localparam logic [15:0] E_42   = 16'hFF42;
    localparam logic [15:0] E_7    = 16'hFFF7;
`else
    localparam logic [15:0] E_0    = 16'h0000;
    localparam logic [15:0] E_5    = 16'h0005;
    localparam logic [15:0] E_42   = 16'h0042;
    localparam logic [15:0] E_7    = 16'h0007;
`endif

    logic         clk   = 1'b0;
    logic         rst   = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] value = '0;
    logic         busy;
    logic         done;
    logic         ovf;
    logic [3:0]   A;
    logic [3:0]   B;
    logic [3:0]   C;
    logic [3:0]   D;

    int tests = 0;
    int fails = 0;

    bcd_conv_ctrl #(.WIDTH(W), .MAXVAL(MAXV)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .value (value),
        .busy  (busy),
        .done  (done),
        .ovf   (ovf),
        .A     (A),
        .B     (B),
        .C     (C),
        .D     (D)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // Decimal digits of the saturated value, optionally blanked.
    function automatic logic [15:0] exp_digits(input int v);
        int s;
        logic [3:0] d [4];
        bit lead;
        s    = (v > MAXV) ? MAXV : v;
        d[0] = 4'(s / 1000);
        d[1] = 4'((s / 100) % 10);
        d[2] = 4'((s / 10) % 10);
        d[3] = 4'(s % 10);
        lead = 1'b1;
`ifdef BCD_BLANK_EN
        for (int i = 0; i < 3; i++) begin
            if (lead && d[i] == 4'd0) d[i] = 4'hF;
            else lead = 1'b0;
        end
`endif
        return {d[0], d[1], d[2], d[3]};
    endfunction

    // Model: a request is in flight for LAT edges after acceptance.
    bit          m_act = 1'b0;
    bit          m_done = 1'b0;
    bit          m_ovf = 1'b0;
    logic [15:0] m_dig = '0;
    int          ec = 0;
    int          m_acc = 0;
    int          m_val = 0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act  <= 1'b0;
            m_done <= 1'b0;
            m_ovf  <= 1'b0;
            m_dig  <= '0;
            ec     <= 0;
        end else begin
            ec     <= ec + 1;
            m_done <= 1'b0;
            if (m_act) begin
                if (ec == m_acc + LAT) begin
                    m_act  <= 1'b0;
                    m_done <= 1'b1;
                    m_dig  <= exp_digits(m_val);
                    m_ovf  <= (m_val > MAXV);
                end
            end else if (start) begin
                m_act <= 1'b1;
                m_acc <= ec;
                m_val <= int'(value);
            end
        end
    end

    always @(negedge clk) begin
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_done));
        chk("ovf", 32'(ovf), 32'(m_ovf));
        chk("digits", 32'({A, B, C, D}), 32'(m_dig));
    end

    task automatic wait_done(input string n, output int cyc);
        cyc = 1;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        chk({n, "_done_seen"}, 32'(done), 32'd1);
    endtask

    task automatic conv(input int v, input string n, output int cyc);
        @(negedge clk);
        start = 1'b1;
        value = W'(v);
        @(negedge clk);
        start = 1'b0;
        value = W'($urandom);
        wait_done(n, cyc);
    endtask

    int n;
    int bnd [6] = '{0, 1, 9998, 9999, 10000, 16383};

    initial begin
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;

        conv(1234, "t1", n);
        chk("t1_latency", 32'(n), 32'(W + 2));
        chk("t1_digits", 32'({A, B, C, D}), 32'h1234);
        chk("t1_ovf", 32'(ovf), 32'd0);

        conv(0, "t2a", n);
        chk("t2_zero", 32'({A, B, C, D}), 32'(E_0));
        conv(9999, "t2b", n);
        chk("t2_max", 32'({A, B, C, D}), 32'h9999);
        chk("t2_max_ovf", 32'(ovf), 32'd0);

        conv(12000, "t3a", n);
        chk("t3_sat", 32'({A, B, C, D}), 32'h9999);
        chk("t3_sat_ovf", 32'(ovf), 32'd1);
        conv(5, "t3b", n);
        chk("t3_five", 32'({A, B, C, D}), 32'(E_5));
        chk("t3_ovf_clr", 32'(ovf), 32'd0);

        @(negedge clk);
        start = 1'b1;
        value = W'(4321);
        @(negedge clk);
        value = W'(1111);
        wait_done("t4a", n);
        chk("t4_first", 32'({A, B, C, D}), 32'h4321);
        @(negedge clk);
        start = 1'b0;
        wait_done("t4b", n);
        chk("t4_gap", 32'(n), 32'(W + 2));
        chk("t4_second", 32'({A, B, C, D}), 32'h1111);

        @(negedge clk);
        start = 1'b1;
        value = W'(8765);
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("t5_rst_digits", 32'({A, B, C, D}), 32'h0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        conv(8765, "t5", n);
        chk("t5_digits", 32'({A, B, C, D}), 32'h8765);

        conv(42, "t6a", n);
        chk("t6_first", 32'({A, B, C, D}), 32'(E_42));
        start = 1'b1;
        value = W'(7);
        @(negedge clk);
        start = 1'b0;
        wait_done("t6b", n);
        chk("t6_spacing", 32'(n), 32'(W + 2));
        chk("t6_second", 32'({A, B, C, D}), 32'(E_7));

        conv(16383, "t7", n);
        chk("t7_ones", 32'({A, B, C, D}), 32'h9999);
        chk("t7_ones_ovf", 32'(ovf), 32'd1);

        repeat (800) begin
            @(negedge clk);
            start = ($urandom % 4 == 0);
            if ($urandom % 6 == 0) value = W'(bnd[$urandom % 6]);
            else value = W'($urandom);
            if ($urandom % 300 == 0) begin
                #2 rst = 1'b0;
                #2 rst = 1'b1;
            end
        end
        start = 1'b0;
        repeat (20) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
